lfsr_gen: RTL and testbench

- Parametrised Fibonacci LFSR pseudo-random generator.
- Successor to the 32-bit single-bit-out LFSR. Width, tap mask and bits-per-step are configurable.
- Output is a registered word with a valid/ready handshake. Includes all-zero lockup protection, a step counter and a period-wrap detector.
- Sits between the control/seed logic and stream consumers: BIST pattern sources, scramblers, test stimulus.

---
 rtl/lfsr_gen.sv | 157 +++++++++++++++
 tb/tb_lfsr_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen
//
// Parametrised Fibonacci LFSR pseudo-random generator with a registered
// output word and a valid/ready handshake. Each accepted step advances the
// register by OUT_BITS single-bit sub-shifts and presents the bits that were
// shifted out (oldest in bit 0). The generator also provides:
//   - all-zero lockup protection (a zero seed is replaced by RESET_SEED),
//   - a saturating step counter,
//   - a wrap pulse whenever the state returns to the start state.
//
// Parameters:
//   WIDTH       LFSR register width (2..64)
//   TAPS        WIDTH-bit feedback mask; feedback = XOR of masked state bits
//   OUT_BITS    bits produced per step (1..WIDTH)
//   RESET_SEED  non-zero state used at reset and in place of a zero seed
//   CNT_W       step counter width
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   ld_en       load seed (highest priority after reset)
//   shift_en    request to advance the generator
//   seed        seed value, sampled when ld_en=1
//   out_data    generated bits, bit 0 is the oldest
//   out_valid   out_data holds an unconsumed word
//   out_ready   consumer accepts out_data this cycle
//   lfsr_state  current register contents
//   step_cnt    steps since last reset or load, saturating at all-ones
//   wrap        one-cycle pulse after a step that returns to the start state
//   zero_seed   sticky flag: a zero seed was loaded and replaced
// ---------------------------------------------------------------------------
module lfsr_gen #(
  parameter int unsigned             WIDTH      = 32,
  parameter logic [WIDTH-1:0]        TAPS       = WIDTH'(32'hC000_0801),
  parameter int unsigned             OUT_BITS   = 1,
  parameter logic [WIDTH-1:0]        RESET_SEED = WIDTH'(1),
  parameter int unsigned             CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_en,
  input  logic                shift_en,
  input  logic [WIDTH-1:0]    seed,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    lfsr_state,
  output logic [CNT_W-1:0]    step_cnt,
  output logic                wrap,
  output logic                zero_seed
);

  // Architectural registers and their next-state values
  logic [WIDTH-1:0]    state_q,    state_d;
  logic [WIDTH-1:0]    start_q,    start_d;
  logic [OUT_BITS-1:0] data_q,     data_d;
  logic                valid_q,    valid_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic                wrap_q,     wrap_d;
  logic                zeroSeen_q, zeroSeen_d;

  // Helper nets
  logic [WIDTH-1:0]    advanced;
  logic [WIDTH-1:0]    loadValue;
  logic                seedIsZero;
  logic                doStep;
  logic                cntFull;

  // Advance the register by OUT_BITS sub-shifts in a single cycle. Each
  // sub-shift drops bit 0 (the bit handed to the consumer) and inserts the
  // XOR of the tapped bits at the top, so bit 0 of the pre-step state is
  // the oldest output bit.
  always_comb begin
    advanced = state_q;
    for (int i = 0; i < int'(OUT_BITS); i++) begin
      advanced = {^(advanced & TAPS), advanced[WIDTH-1:1]};
    end
  end

  // A zero seed would lock the LFSR at zero forever, so it is swapped for
  // the reset seed and the event is remembered in the sticky flag.
  always_comb begin
    seedIsZero = (seed == '0);
    loadValue  = seedIsZero ? RESET_SEED : seed;
  end

  // A step may only happen when the output slot is free or being emptied
  // in this same cycle; a pending load always wins over stepping.
  always_comb begin
    doStep  = shift_en & ~ld_en & (~valid_q | out_ready);
    cntFull = (cnt_q == {CNT_W{1'b1}});
  end

  // Next-state selection. Priority: load, then step, then a plain consume
  // (accept without a new word), otherwise everything holds. Under
  // backpressure doStep is already low, so the hold branch freezes the
  // word, the valid flag and the LFSR state together.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    data_d     = data_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    zeroSeen_d = zeroSeen_q;

    if (ld_en) begin
      state_d    = loadValue;
      start_d    = loadValue;
      valid_d    = 1'b0;
      cnt_d      = '0;
      zeroSeen_d = zeroSeen_q | seedIsZero;
    end else if (doStep) begin
      state_d = advanced;
      data_d  = state_q[OUT_BITS-1:0];
      valid_d = 1'b1;
      cnt_d   = cntFull ? cnt_q : cnt_q + CNT_W'(1);
      wrap_d  = (advanced == start_q);
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State register. Reset is asynchronous so that a word in flight is
  // dropped immediately and no wrap pulse can escape afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_SEED;
      start_q    <= RESET_SEED;
      data_q     <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      zeroSeen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      zeroSeen_q <= zeroSeen_d;
    end
  end

  // All outputs come straight from registers
  always_comb begin
    out_data   = data_q;
    out_valid  = valid_q;
    lfsr_state = state_q;
    step_cnt   = cnt_q;
    wrap       = wrap_q;
    zero_seed  = zeroSeen_q;
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_gen
//
// Self-checking bench for lfsr_gen. Three instances are exercised:
//   dutA: WIDTH=4, TAPS=0011, OUT_BITS=1, CNT_W=4 (table-driven main checks)
//   dutB: WIDTH=4, TAPS=0011, OUT_BITS=2 (multi-bit step)
//   dutC: default 32-bit configuration
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_lfsr_gen;

  logic clk;
  logic rst;

  // dutA signals
  logic       ldA, shA, rdyA;
  logic [3:0] seedA;
  logic [0:0] dataA;
  logic       validA, wrapA, zeroA;
  logic [3:0] stateA;
  logic [3:0] cntA;

  // dutB signals
  logic       ldB, shB, rdyB;
  logic [3:0] seedB;
  logic [1:0] dataB;
  logic       validB, wrapB, zeroB;
  logic [3:0] stateB;
  logic [7:0] cntB;

  // dutC signals
  logic        ldC, shC, rdyC;
  logic [31:0] seedC;
  logic [0:0]  dataC;
  logic        validC, wrapC, zeroC;
  logic [31:0] stateC;
  logic [31:0] cntC;

  int testsRun = 0;
  int failures = 0;

  typedef struct {
    logic       ld;
    logic       sh;
    logic       rdy;
    logic [3:0] seed;
    logic       valid;
    logic       data;
    logic [3:0] state;
    logic [3:0] cnt;
    logic       wrap;
    logic       zero;
  } vec_t;

  vec_t vecs[$];

  lfsr_gen #(
    .WIDTH(4), .TAPS(4'b0011), .OUT_BITS(1), .RESET_SEED(4'b0001), .CNT_W(4)
  ) dutA (
    .clk(clk), .rst(rst), .ld_en(ldA), .shift_en(shA), .seed(seedA),
    .out_data(dataA), .out_valid(validA), .out_ready(rdyA),
    .lfsr_state(stateA), .step_cnt(cntA), .wrap(wrapA), .zero_seed(zeroA)
  );

  lfsr_gen #(
    .WIDTH(4), .TAPS(4'b0011), .OUT_BITS(2), .RESET_SEED(4'b0001), .CNT_W(8)
  ) dutB (
    .clk(clk), .rst(rst), .ld_en(ldB), .shift_en(shB), .seed(seedB),
    .out_data(dataB), .out_valid(validB), .out_ready(rdyB),
    .lfsr_state(stateB), .step_cnt(cntB), .wrap(wrapB), .zero_seed(zeroB)
  );

  lfsr_gen dutC (
    .clk(clk), .rst(rst), .ld_en(ldC), .shift_en(shC), .seed(seedC),
    .out_data(dataC), .out_valid(validC), .out_ready(rdyC),
    .lfsr_state(stateC), .step_cnt(cntC), .wrap(wrapC), .zero_seed(zeroC)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one dutA vector on the falling edge, then sample after the
  // following rising edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    ldA   = v.ld;
    shA   = v.sh;
    rdyA  = v.rdy;
    seedA = v.seed;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic ld, input logic sh, input logic rdy,
                        input logic [3:0] seed, input logic valid,
                        input logic data, input logic [3:0] state,
                        input logic [3:0] cnt, input logic wrap,
                        input logic zero);
    vec_t v;
    v.ld = ld; v.sh = sh; v.rdy = rdy; v.seed = seed;
    v.valid = valid; v.data = data; v.state = state; v.cnt = cnt;
    v.wrap = wrap; v.zero = zero;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] seqStates [15];
    logic       seqBits   [15];
    logic [1:0] bData     [3];
    logic [3:0] bState    [3];
    string      tag;

    // Hand-computed 4-bit sequence from seed 0001 and the bits shifted out
    seqStates = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                  4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
    seqBits   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    // Two-bit steps from 0001: 0001->0100->1001->0110
    bData  = '{2'b01, 2'b00, 2'b01};
    bState = '{4'b0100, 4'b1001, 4'b0110};

    // ---- vector table for dutA: ld sh rdy seed | valid data state cnt wrap zero
    addVec(1, 0, 0, 4'h1,  0, 0, 4'h1, 4'd0, 0, 0);
    for (int k = 1; k <= 15; k++)
      addVec(0, 1, 1, 4'h0, 1, seqBits[k-1], seqStates[k-1], 4'(k), (k == 15), 0);
    addVec(0, 0, 1, 4'h0,  0, 1, 4'h1, 4'd15, 0, 0);  // consume only
    addVec(0, 1, 1, 4'h0,  1, 1, 4'h8, 4'd15, 0, 0);  // counter saturates
    addVec(1, 0, 0, 4'h1,  0, 1, 4'h1, 4'd0,  0, 0);  // reload clears count
    addVec(0, 1, 0, 4'h0,  1, 1, 4'h8, 4'd1,  0, 0);  // first word
    for (int k = 0; k < 5; k++)
      addVec(0, 1, 0, 4'h0, 1, 1, 4'h8, 4'd1, 0, 0);  // backpressure hold
    addVec(0, 1, 1, 4'h0,  1, 0, 4'h4, 4'd2,  0, 0);  // resume
    addVec(0, 1, 1, 4'h0,  1, 0, 4'h2, 4'd3,  0, 0);
    addVec(0, 0, 1, 4'h0,  0, 0, 4'h2, 4'd3,  0, 0);
    addVec(0, 0, 0, 4'h0,  0, 0, 4'h2, 4'd3,  0, 0);
    addVec(1, 0, 0, 4'h0,  0, 0, 4'h1, 4'd0,  0, 1);  // zero seed replaced
    addVec(0, 1, 1, 4'h0,  1, 1, 4'h8, 4'd1,  0, 1);
    addVec(1, 1, 1, 4'h5,  0, 1, 4'h5, 4'd0,  0, 1);  // load wins, flag sticks
    addVec(0, 1, 1, 4'h0,  1, 1, 4'hA, 4'd1,  0, 1);

    // ---- reset state
    rst = 1'b1;
    ldA = 0; shA = 0; rdyA = 0; seedA = '0;
    ldB = 0; shB = 0; rdyB = 0; seedB = '0;
    ldC = 0; shC = 0; rdyC = 0; seedC = '0;
    #2;
    checkOutput("rstA state", 64'(stateA), 64'h1);
    checkOutput("rstA valid", 64'(validA), 64'h0);
    checkOutput("rstA cnt",   64'(cntA),   64'h0);
    checkOutput("rstA data",  64'(dataA),  64'h0);
    checkOutput("rstA wrap",  64'(wrapA),  64'h0);
    checkOutput("rstA zero",  64'(zeroA),  64'h0);
    checkOutput("rstC state", 64'(stateC), 64'h1);
    @(negedge clk);
    rst = 1'b0;

    // ---- table-driven checks on dutA
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tag = $sformatf("vec%0d", i);
      checkOutput({tag, " valid"}, 64'(validA), 64'(vecs[i].valid));
      checkOutput({tag, " data"},  64'(dataA),  64'(vecs[i].data));
      checkOutput({tag, " state"}, 64'(stateA), 64'(vecs[i].state));
      checkOutput({tag, " cnt"},   64'(cntA),   64'(vecs[i].cnt));
      checkOutput({tag, " wrap"},  64'(wrapA),  64'(vecs[i].wrap));
      checkOutput({tag, " zero"},  64'(zeroA),  64'(vecs[i].zero));
    end

    // ---- asynchronous reset in the middle of a cycle with a pending word
    @(negedge clk);
    ldA = 0; shA = 0; rdyA = 0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRst state", 64'(stateA), 64'h1);
    checkOutput("midRst valid", 64'(validA), 64'h0);
    checkOutput("midRst cnt",   64'(cntA),   64'h0);
    checkOutput("midRst zero",  64'(zeroA),  64'h0);
    checkOutput("midRst data",  64'(dataA),  64'h0);
    @(negedge clk);
    rst = 1'b0;

    // ---- two full periods from the reset seed: wrap on steps 15 and 30
    shA = 1; rdyA = 1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      tag = $sformatf("period step%0d", i);
      checkOutput({tag, " wrap"},  64'(wrapA),  64'(i % 15 == 0));
      checkOutput({tag, " state"}, 64'(stateA), 64'(seqStates[(i-1) % 15]));
      checkOutput({tag, " cnt"},   64'(cntA),   64'((i > 15) ? 15 : i));
    end
    @(negedge clk);
    shA = 0; rdyA = 0;

    // ---- multi-bit step on dutB
    ldB = 1; seedB = 4'h1;
    @(posedge clk);
    #1;
    checkOutput("B load state", 64'(stateB), 64'h1);
    @(negedge clk);
    ldB = 0; shB = 1; rdyB = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tag = $sformatf("B step%0d", i + 1);
      checkOutput({tag, " data"},  64'(dataB),  64'(bData[i]));
      checkOutput({tag, " state"}, 64'(stateB), 64'(bState[i]));
      checkOutput({tag, " valid"}, 64'(validB), 64'h1);
      checkOutput({tag, " cnt"},   64'(cntB),   64'(i + 1));
    end
    @(negedge clk);
    shB = 0; rdyB = 0;

    // ---- default 32-bit config: load with shift_en, then two steps
    ldC = 1; shC = 1; rdyC = 1; seedC = 32'h0000_0001;
    @(posedge clk);
    #1;
    checkOutput("C load state", 64'(stateC), 64'h1);
    checkOutput("C load valid", 64'(validC), 64'h0);
    checkOutput("C load cnt",   64'(cntC),   64'h0);
    @(negedge clk);
    ldC = 0;
    @(posedge clk);
    #1;
    checkOutput("C step1 data",  64'(dataC),  64'h1);
    checkOutput("C step1 state", 64'(stateC), 64'h8000_0000);
    checkOutput("C step1 valid", 64'(validC), 64'h1);
    checkOutput("C step1 cnt",   64'(cntC),   64'h1);
    @(posedge clk);
    #1;
    checkOutput("C step2 data",  64'(dataC),  64'h0);
    checkOutput("C step2 state", 64'(stateC), 64'hC000_0000);
    checkOutput("C step2 cnt",   64'(cntC),   64'h2);
    @(negedge clk);
    shC = 0; rdyC = 0;

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
